// File: rtl/ram8_pkg.sv
// Shared constants and types for the RAM8 two-requester arbiter.
package ram8_pkg;

  localparam int unsigned RAM8_DATA_WIDTH    = 16;
  localparam int unsigned RAM8_ADDRESS_WIDTH = 3;

  // Requester ids; also the bit positions in the req/gnt vectors.
  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/ram8_if.sv
// Requester-side bus for both RAM8 clients (A and B).
interface ram8_if
  import ram8_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = RAM8_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = RAM8_ADDRESS_WIDTH
);

  logic                     a_req;
  logic                     a_we;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic                     a_gnt;
  logic                     a_rvalid;
  logic [DATA_WIDTH-1:0]    a_rdata;

  logic                     b_req;
  logic                     b_we;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]    b_wdata;
  logic                     b_gnt;
  logic                     b_rvalid;
  logic [DATA_WIDTH-1:0]    b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata
  );

endinterface

// File: rtl/ram8.sv
// 8x16 RAM with combinational read and write at the clock edge.
module ram8
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    in,
  input  logic                     load,
  output logic [DATA_WIDTH-1:0]    out
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (load) mem[address] <= in;
  end

  assign out = mem[address];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last = id of the previous grantee (0=A, 1=B).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone requester wins; on conflict the one not granted last wins.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one RAM8 between requesters A and B: clear-after-reset, then
// round-robin single-cycle grants with registered read return.
module ram8_arbiter
  import ram8_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RAM8_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = RAM8_ADDRESS_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ram8_if.slave                    bus,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_in,
  output logic                     ram_load,
  input  logic [DATA_WIDTH-1:0]    ram_out,
  output logic                     busy
);

  localparam int unsigned LAST_ADDR = (2 ** ADDRESS_WIDTH) - 1;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clr_cnt;
  logic [ADDRESS_WIDTH-1:0] held_address;
  logic                     rr_last;
  logic                     serve;
  logic [1:0]               req;
  logic [1:0]               gnt;

  // Grants only in SERVE and never while reset is asserted.
  assign serve = reset_n && (state == SERVE);
  assign req   = serve ? {bus.b_req, bus.a_req} : 2'b00;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (rr_last),
    .gnt  (gnt)
  );

  assign bus.a_gnt = gnt[REQ_A];
  assign bus.b_gnt = gnt[REQ_B];
  assign busy      = (state == CLEAR);

  // RAM port mux: clear engine, then the grantee; idle keeps the address.
  always_comb begin
    ram_address = held_address;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (state == CLEAR) begin
      ram_address = clr_cnt;
      ram_load    = reset_n;
    end else if (gnt[REQ_A]) begin
      ram_address = bus.a_addr;
      ram_in      = bus.a_wdata;
      ram_load    = bus.a_we;
    end else if (gnt[REQ_B]) begin
      ram_address = bus.b_addr;
      ram_in      = bus.b_wdata;
      ram_load    = bus.b_we;
    end
  end

  // State, clear counter, round-robin pointer and read-return registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= CLEAR_ON_RESET ? CLEAR : SERVE;
      clr_cnt      <= '0;
      held_address <= '0;
      rr_last      <= 1'(REQ_B);
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      held_address <= ram_address;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_cnt == ADDRESS_WIDTH'(LAST_ADDR)) state <= SERVE;
          else clr_cnt <= clr_cnt + ADDRESS_WIDTH'(1);
        end
        SERVE: begin
          if (gnt[REQ_A]) begin
            rr_last <= 1'(REQ_A);
            if (!bus.a_we) begin
              bus.a_rdata  <= ram_out;
              bus.a_rvalid <= 1'b1;
            end
          end
          if (gnt[REQ_B]) begin
            rr_last <= 1'(REQ_B);
            if (!bus.b_we) begin
              bus.b_rdata  <= ram_out;
              bus.b_rvalid <= 1'b1;
            end
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter driving a real ram8, with a behavioural model.
module tb_ram8_arbiter;
  import ram8_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
  logic        busy;

  int n_checks;
  int n_pass;

  ram8_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) bus ();

  ram8_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .busy        (busy)
  );

  ram8 #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) u_ram (
    .clk     (clk),
    .address (ram_address),
    .in      (ram_in),
    .load    (ram_load),
    .out     (ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: memory array, clear progress, last winner, read returns.
  logic [15:0] m_mem [8];
  int          m_k;
  bit          m_valid;
  bit          m_last_b;
  bit          m_rv_a, m_rv_b;
  logic [15:0] m_rd_a, m_rd_b;
  logic [2:0]  m_held;

  initial begin : model
    bit          rst, clearing, ga, gb, e_load;
    logic [2:0]  e_addr;
    logic [15:0] e_in;
    m_valid = 0; m_k = 0; m_last_b = 1; m_rv_a = 0; m_rv_b = 0;
    m_rd_a = '0; m_rd_b = '0; m_held = '0;
    forever begin
      @(negedge clk);
      rst      = !reset_n;
      clearing = (m_k < 8);
      ga = 0; gb = 0;
      if (m_valid && !rst && !clearing) begin
        if (bus.a_req && bus.b_req) begin
          ga = m_last_b;
          gb = !m_last_b;
        end else begin
          ga = bus.a_req;
          gb = bus.b_req;
        end
      end
      e_addr = m_held; e_in = '0; e_load = 0;
      if (clearing) begin
        e_addr = 3'(m_k);
        e_load = !rst;
      end else if (ga) begin
        e_addr = bus.a_addr; e_in = bus.a_wdata; e_load = bus.a_we;
      end else if (gb) begin
        e_addr = bus.b_addr; e_in = bus.b_wdata; e_load = bus.b_we;
      end
      if (m_valid) begin
        check("a_gnt", 32'(bus.a_gnt), 32'(ga));
        check("b_gnt", 32'(bus.b_gnt), 32'(gb));
        check("busy", 32'(busy), 32'(clearing));
        check("ram_load", 32'(ram_load), 32'(e_load));
        check("ram_address", 32'(ram_address), 32'(e_addr));
        check("ram_in", 32'(ram_in), 32'(e_in));
        check("a_rvalid", 32'(bus.a_rvalid), 32'(m_rv_a));
        check("b_rvalid", 32'(bus.b_rvalid), 32'(m_rv_b));
        check("a_rdata", 32'(bus.a_rdata), 32'(m_rd_a));
        check("b_rdata", 32'(bus.b_rdata), 32'(m_rd_b));
      end
      @(posedge clk);
      if (rst) begin
        m_valid = 1; m_k = 0; m_last_b = 1; m_rv_a = 0; m_rv_b = 0;
        m_rd_a = '0; m_rd_b = '0; m_held = '0;
      end else if (m_valid) begin
        m_held = e_addr;
        m_rv_a = 0; m_rv_b = 0;
        if (clearing) begin
          m_mem[3'(m_k)] = '0;
          m_k++;
        end else if (ga || gb) begin
          if (e_load) m_mem[e_addr] = e_in;
          else if (ga) begin m_rd_a = m_mem[e_addr]; m_rv_a = 1; end
          else begin m_rd_b = m_mem[e_addr]; m_rv_b = 1; end
          m_last_b = gb;
        end
      end
    end
  end

  task automatic set_req(input bit side, input bit req, input bit we,
                         input logic [2:0] addr, input logic [15:0] wd);
    if (side) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
  endtask

  // One access, held until granted; reads check the returned word literally.
  task automatic access(input bit side, input bit we, input logic [2:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
    bit got;
    got = 0;
    @(posedge clk); #1;
    set_req(side, 1, we, addr, wd);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = side ? bus.b_gnt : bus.a_gnt;
    end
    check(side ? "b_gnt_wait" : "a_gnt_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    set_req(side, 0, 0, addr, wd);
    if (!we) begin
      @(negedge clk);
      check(side ? "b_rvalid_lit" : "a_rvalid_lit",
            32'(side ? bus.b_rvalid : bus.a_rvalid), 32'd1);
      check(side ? "b_rdata_lit" : "a_rdata_lit",
            32'(side ? bus.b_rdata : bus.a_rdata), 32'(exp_rd));
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit ga_s, gb_s, a_was, b_was;
    n_checks = 0; n_pass = 0;
    reset_n = 0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // Clear sequence: 8 busy cycles zeroing addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_addr", 32'(ram_address), 32'(i));
      check("clr_load", 32'(ram_load), 32'd1);
    end
    @(negedge clk);
    check("clr_done", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) access(0, 0, 3'(i), '0, 16'h0000);

    // A write then read.
    access(0, 1, 3'd0, 16'hA5A5, '0);
    access(0, 0, 3'd0, '0, 16'hA5A5);
    check("b_rvalid_idle", 32'(bus.b_rvalid), 32'd0);

    // B access so A wins the next conflict.
    access(1, 1, 3'd7, 16'h1234, '0);

    // Conflict: A write 5A5A @1, B read @1.
    @(posedge clk); #1;
    set_req(0, 1, 1, 3'd1, 16'h5A5A);
    set_req(1, 1, 0, 3'd1, '0);
    @(negedge clk);
    check("conf_a_gnt", 32'(bus.a_gnt), 32'd1);
    check("conf_b_gnt0", 32'(bus.b_gnt), 32'd0);
    @(posedge clk); #1 bus.a_req = 0;
    @(negedge clk);
    check("conf_b_gnt1", 32'(bus.b_gnt), 32'd1);
    @(posedge clk); #1 bus.b_req = 0;
    @(negedge clk);
    check("conf_b_rvalid", 32'(bus.b_rvalid), 32'd1);
    check("conf_b_rdata", 32'(bus.b_rdata), 32'h5A5A);

    // Both hold reads: grants alternate A,B,...
    @(posedge clk); #1;
    set_req(0, 1, 0, 3'd0, '0);
    set_req(1, 1, 0, 3'd1, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_a_gnt", 32'(bus.a_gnt), 32'(i % 2 == 0));
      check("alt_b_gnt", 32'(bus.b_gnt), 32'(i % 2 == 1));
      check("alt_a_rvalid", 32'(bus.a_rvalid), 32'(i % 2 == 1));
      check("alt_b_rvalid", 32'(bus.b_rvalid), 32'(i % 2 == 0 && i > 0));
      if (i % 2 == 1) check("alt_a_rdata", 32'(bus.a_rdata), 32'hA5A5);
    end
    @(posedge clk); #1;
    bus.a_req = 0; bus.b_req = 0;

    // Request held during clear is granted on the first SERVE cycle.
    pulse_reset();
    @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1, 1, 3'd2, 16'hFFFF);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("clr_hold_gnt", 32'(bus.a_gnt), 32'd0);
    end
    @(negedge clk);
    check("first_serve_gnt", 32'(bus.a_gnt), 32'd1);
    check("first_serve_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 bus.a_req = 0;
    access(0, 0, 3'd2, '0, 16'hFFFF);

    // Reset during clear count 4 restarts from 0.
    pulse_reset();
    repeat (4) @(negedge clk);
    @(posedge clk); #1 reset_n = 0;
    @(negedge clk);
    check("rst4_addr", 32'(ram_address), 32'd4);
    check("rst4_load", 32'(ram_load), 32'd0);
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reclr_addr", 32'(ram_address), 32'(i));
      check("reclr_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("reclr_done", 32'(busy), 32'd0);

    // Read request coinciding with reset produces no rvalid.
    @(posedge clk); #1;
    set_req(0, 1, 0, 3'd3, '0);
    reset_n = 0;
    @(negedge clk);
    check("rst_rd_gnt", 32'(bus.a_gnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    bus.a_req = 0;
    @(negedge clk);
    check("rst_rd_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("rst_rd_busy", 32'(busy), 32'd1);
    repeat (9) @(negedge clk);

    // Randomized traffic with withdrawals and occasional resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      ga_s = bus.a_gnt; gb_s = bus.b_gnt;
      @(posedge clk); #1;
      a_was = bus.a_req; b_was = bus.b_req;
      if (a_was && (ga_s || $urandom_range(0, 9) == 0)) bus.a_req = 0;
      if (b_was && (gb_s || $urandom_range(0, 9) == 0)) bus.b_req = 0;
      if (!a_was && $urandom_range(0, 2) != 0)
        set_req(0, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      if (!b_was && $urandom_range(0, 2) != 0)
        set_req(1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 149) == 0) reset_n = 0;
    end
    @(posedge clk); #1;
    bus.a_req = 0; bus.b_req = 0; reset_n = 1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram8_arbiter.md
Name: ram8_arbiter

Overview:
- Shares one 8x16 RAM8 instance between two requesters, A (CPU data side) and B (debug/loader side).
- After reset, a clear engine zeroes every word before any request is accepted.
- Arbitration is round-robin with single-cycle grants. Read data returns on a registered path one cycle after grant.
- Sits between the requesters and the RAM8 address/in/load/out ports.

Parameters:
- DATA_WIDTH, 16, data word width (must match RAM8).
- ADDRESS_WIDTH, 3, address width; depth is 2**ADDRESS_WIDTH = 8.
- CLEAR_ON_RESET, 1, 1 = run the zeroing sequence after reset; 0 = go straight to SERVE.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- a_req  in  1  A request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDRESS_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A request accepted this cycle.
- a_rvalid  out  1  A read data valid, one-cycle pulse.
- a_rdata  out  DATA_WIDTH  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same set of ports and rules for requester B.
- ram_address  out  ADDRESS_WIDTH  to RAM8 address.
- ram_in  out  DATA_WIDTH  to RAM8 in.
- ram_load  out  1  to RAM8 load; the write takes effect at the clock edge ending the cycle.
- ram_out  in  DATA_WIDTH  from RAM8 out; combinational read of ram_address.
- busy  out  1  high while clearing.

Behaviour:
- States: CLEAR, SERVE.
- Reset (reset_n low at an edge) sets:
  - state to CLEAR if CLEAR_ON_RESET, else SERVE;
  - clr_cnt to 0;
  - rr_last to B, so A wins the first conflict;
  - a_rvalid, b_rvalid to 0;
  - a_rdata, b_rdata to 0.
- While reset_n is low, ram_load, a_gnt and b_gnt are forced to 0 combinationally.
- CLEAR state:
  - busy=1, ram_load=1, ram_in=0, ram_address=clr_cnt; both gnt=0.
  - clr_cnt increments each cycle. At clr_cnt==7, go to SERVE on the next edge.
  - Duration is exactly 8 cycles. Requests are ignored (held, not dropped) during CLEAR.
- SERVE grant rule (combinational):
  - Only one requester asserting req: grant it.
  - Both asserting req: grant the one that is not rr_last.
  - On any grant, rr_last is set to the grantee at the edge.
- Granted cycle datapath:
  - ram_address = grantee addr, ram_in = grantee wdata, ram_load = grantee we.
- No grant:
  - ram_load=0, ram_address holds its last value, ram_in=0.
- Read grant:
  - Grantee's rdata <= ram_out at the grant edge; its rvalid=1 for exactly the next cycle.
  - rdata holds its value until the next read completes for that requester.
- Write grant:
  - No rvalid.
  - A read of the same address in the next cycle returns the new data; no forwarding is needed because the RAM updates at the edge.
- Throughput: one access per cycle. With both requesting continuously, grants alternate A,B,A,B.
- Reset mid-operation:
  - Aborts any pending rvalid (not issued).
  - Restarts CLEAR from address 0.
  - A partially completed clear is not resumed.
- Requester dropping req before gnt: legal; the request is withdrawn and rr_last is unchanged.
- Address wrap: clr_cnt is ADDRESS_WIDTH bits and is compared, not wrapped; no other counters.

Decomposition:
- Package ram8_pkg holds:
  - DATA_WIDTH/ADDRESS_WIDTH defaults;
  - state enum {CLEAR, SERVE};
  - requester id constants REQ_A=0, REQ_B=1.
- One sub-module is natural: rr_arbiter2 (2-way round-robin: req[1:0], last, gnt[1:0]). Clear engine and read-return registers stay in the top.
- The bench instantiates the real RAM8 behind the arbiter.

Test Plan:
- Reset then release -> busy=1 for exactly 8 cycles, ram_load=1 with ram_address 0..7 and ram_in=0; then a read of each address via A returns 0000.
- A writes A5A5 to addr 0, then reads addr 0 -> a_gnt in the request cycle; a_rvalid the cycle after the read grant with a_rdata=A5A5; b_rvalid stays 0.
- A and B request together (A write 5A5A addr 1, B read addr 1), held -> A granted first, B next cycle; b_rdata=5A5A.
- Both hold reads for 6 cycles -> grants alternate A,B,A,B,A,B; each rvalid is a single-cycle pulse.
- Requests during CLEAR (A write FFFF addr 2 from cycle 1) -> no gnt until SERVE; granted on the first SERVE cycle; the later read returns FFFF (not overwritten by clear).
- reset_n low for one edge during clear count 4 and during a pending read -> no rvalid emitted; clear restarts at address 0 and runs 8 full cycles.
